// File: rtl/eth_decap.sv
`default_nettype none
// ============================================================================
//  Module   : eth_decap
//  Brief    : Strips the 14-byte Ethernet L2 header from a 64-bit AXI-Stream
//             frame, presents MACs/EtherType as registered sideband and emits
//             the payload realigned to lane 0 (clk156 domain).
//  Revision : 1.0  initial release
// ============================================================================
module eth_decap #(
    parameter bit          ETYPE_FILTER_EN = 1'b0,
    parameter logic [15:0] ETYPE_MATCH     = 16'h0800,
    parameter int          CNT_W           = 16
) (
    input  logic             clk156,
    input  logic             eth_rst,
    output logic [7:0]       debug,
    input  logic             s_axis_rx0_tvalid,
    output logic             s_axis_rx0_tready,
    input  logic [63:0]      s_axis_rx0_tdata,
    input  logic [7:0]       s_axis_rx0_tkeep,
    input  logic             s_axis_rx0_tlast,
    input  logic             s_axis_rx0_tuser,
    output logic             m_axis_pl_tvalid,
    input  logic             m_axis_pl_tready,
    output logic [63:0]      m_axis_pl_tdata,
    output logic [7:0]       m_axis_pl_tkeep,
    output logic             m_axis_pl_tlast,
    output logic             m_axis_pl_tuser,
    output logic             hdr_valid,
    output logic [47:0]      hdr_dst_mac,
    output logic [47:0]      hdr_src_mac,
    output logic [15:0]      hdr_ethertype,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [2:0]       c_HDR0    = 3'd0;
    localparam logic [2:0]       c_HDR1    = 3'd1;
    localparam logic [2:0]       c_BODY    = 3'd2;
    localparam logic [2:0]       c_FLUSH   = 3'd3;
    localparam logic [2:0]       c_DROP    = 3'd4;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [63:0]      r_prev_data;
    logic [7:0]       r_prev_keep;
    logic             r_err;
    logic             r_m_tvalid;
    logic [63:0]      r_m_tdata;
    logic [7:0]       r_m_tkeep;
    logic             r_m_tlast;
    logic             r_m_tuser;
    logic             r_hdr_valid;
    logic [47:0]      r_hdr_dst;
    logic [47:0]      r_hdr_src;
    logic [15:0]      r_hdr_etype;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_s_tready;
    logic             w_s_acc;
    logic             w_out_free;
    logic             w_err_next;
    logic [15:0]      w_etype;
    logic             w_runt;
    logic             w_filtered;

    // Input ready depends on state; BODY only accepts when the output slot frees up
    always_comb begin
        w_s_tready = 1'b0;
        case (r_state)
            c_HDR0, c_HDR1, c_DROP: w_s_tready = 1'b1;
            c_BODY:                 w_s_tready = !r_m_tvalid || m_axis_pl_tready;
            default:                w_s_tready = 1'b0;
        endcase
    end

    assign w_s_acc    = s_axis_rx0_tvalid && w_s_tready;
    assign w_out_free = !r_m_tvalid || m_axis_pl_tready;
    assign w_err_next = r_err || s_axis_rx0_tuser;
    // EtherType occupies frame bytes 12,13 = lanes 4,5 of the second beat
    assign w_etype    = {s_axis_rx0_tdata[39:32], s_axis_rx0_tdata[47:40]};
    // A last second beat without lane 6 carries no payload byte at all
    assign w_runt     = s_axis_rx0_tlast && !s_axis_rx0_tkeep[6];
    assign w_filtered = (ETYPE_FILTER_EN != 1'b0) && (w_etype != ETYPE_MATCH);

    // Frame FSM, header capture, payload realignment and status counters
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_state     <= c_HDR0;
            r_prev_data <= 64'd0;
            r_prev_keep <= 8'd0;
            r_err       <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= 64'd0;
            r_m_tkeep   <= 8'd0;
            r_m_tlast   <= 1'b0;
            r_m_tuser   <= 1'b0;
            r_hdr_valid <= 1'b0;
            r_hdr_dst   <= 48'd0;
            r_hdr_src   <= 48'd0;
            r_hdr_etype <= 16'd0;
            r_frame_cnt <= {CNT_W{1'b0}};
            r_drop_cnt  <= {CNT_W{1'b0}};
        end else begin
            r_hdr_valid <= 1'b0;
            if (r_m_tvalid && m_axis_pl_tready) begin
                r_m_tvalid <= 1'b0;
            end
            case (r_state)
                c_HDR0: begin
                    if (w_s_acc) begin
                        r_prev_data <= s_axis_rx0_tdata;
                        r_prev_keep <= s_axis_rx0_tkeep;
                        if (s_axis_rx0_tlast) begin
                            r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
                            r_err      <= 1'b0;
                        end else begin
                            r_err   <= s_axis_rx0_tuser;
                            r_state <= c_HDR1;
                        end
                    end
                end
                c_HDR1: begin
                    if (w_s_acc) begin
                        r_prev_data <= s_axis_rx0_tdata;
                        r_prev_keep <= s_axis_rx0_tkeep;
                        r_err       <= w_err_next;
                        if (w_runt) begin
                            r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
                            r_err      <= 1'b0;
                            r_state    <= c_HDR0;
                        end else if (w_filtered) begin
                            r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
                            if (s_axis_rx0_tlast) begin
                                r_err   <= 1'b0;
                                r_state <= c_HDR0;
                            end else begin
                                r_state <= c_DROP;
                            end
                        end else begin
                            r_hdr_valid <= 1'b1;
                            r_hdr_dst   <= {r_prev_data[7:0],   r_prev_data[15:8],
                                            r_prev_data[23:16], r_prev_data[31:24],
                                            r_prev_data[39:32], r_prev_data[47:40]};
                            r_hdr_src   <= {r_prev_data[55:48], r_prev_data[63:56],
                                            s_axis_rx0_tdata[7:0],   s_axis_rx0_tdata[15:8],
                                            s_axis_rx0_tdata[23:16], s_axis_rx0_tdata[31:24]};
                            r_hdr_etype <= w_etype;
                            r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
                            r_state     <= s_axis_rx0_tlast ? c_FLUSH : c_BODY;
                        end
                    end
                end
                c_BODY: begin
                    if (w_s_acc) begin
                        r_prev_data <= s_axis_rx0_tdata;
                        r_prev_keep <= s_axis_rx0_tkeep;
                        r_m_tvalid  <= 1'b1;
                        r_m_tdata   <= {s_axis_rx0_tdata[47:0], r_prev_data[63:48]};
                        r_m_tkeep   <= {s_axis_rx0_tkeep[5:0], r_prev_keep[7:6]};
                        r_m_tlast   <= 1'b0;
                        r_m_tuser   <= 1'b0;
                        r_err       <= w_err_next;
                        if (w_runt) begin
                            // Last input beat fits entirely in this output beat
                            r_m_tlast <= 1'b1;
                            r_m_tuser <= w_err_next;
                            r_err     <= 1'b0;
                            r_state   <= c_HDR0;
                        end else if (s_axis_rx0_tlast) begin
                            // Bytes in lanes 6/7 spill into one more output beat
                            r_state <= c_FLUSH;
                        end
                    end
                end
                c_FLUSH: begin
                    if (w_out_free) begin
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= {48'd0, r_prev_data[63:48]};
                        r_m_tkeep  <= {6'd0, r_prev_keep[7:6]};
                        r_m_tlast  <= 1'b1;
                        r_m_tuser  <= r_err;
                        r_err      <= 1'b0;
                        r_state    <= c_HDR0;
                    end
                end
                c_DROP: begin
                    if (w_s_acc && s_axis_rx0_tlast) begin
                        r_err   <= 1'b0;
                        r_state <= c_HDR0;
                    end
                end
                default: begin
                    r_state <= c_HDR0;
                end
            endcase
        end
    end

    assign s_axis_rx0_tready = w_s_tready;
    assign m_axis_pl_tvalid  = r_m_tvalid;
    assign m_axis_pl_tdata   = r_m_tdata;
    assign m_axis_pl_tkeep   = r_m_tkeep;
    assign m_axis_pl_tlast   = r_m_tlast;
    assign m_axis_pl_tuser   = r_m_tuser;
    assign hdr_valid         = r_hdr_valid;
    assign hdr_dst_mac       = r_hdr_dst;
    assign hdr_src_mac       = r_hdr_src;
    assign hdr_ethertype     = r_hdr_etype;
    assign frame_cnt         = r_frame_cnt;
    assign drop_cnt          = r_drop_cnt;
    assign debug             = {r_m_tvalid, w_s_tready, 3'b000, r_state};

endmodule
`default_nettype wire

// File: tb/tb_eth_decap.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_decap
//  Brief    : Scoreboard bench for eth_decap; one unfiltered and one filtering
//             instance share a multiplexed stimulus port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eth_decap;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
    } hdr_t;

    logic        clk156 = 1'b0;
    logic        eth_rst;
    logic        sel;
    logic        s_tvalid;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tuser;
    logic        m_tready;
    logic        rnd_rdy;

    logic [7:0]  dbg0, dbg1;
    logic        rdy0, rdy1, mv0, mv1, ml0, ml1, mu0, mu1, hv0, hv1;
    logic [63:0] md0, md1;
    logic [7:0]  mk0, mk1;
    logic [47:0] hd0, hd1, hs0, hs1;
    logic [15:0] he0, he1;
    logic [15:0] fc0, fc1, dc0, dc1;

    wire         s_tready = sel ? rdy1 : rdy0;
    wire         mv       = sel ? mv1  : mv0;
    wire [63:0]  md       = sel ? md1  : md0;
    wire [7:0]   mk       = sel ? mk1  : mk0;
    wire         ml       = sel ? ml1  : ml0;
    wire         mu       = sel ? mu1  : mu0;
    wire         hv       = sel ? hv1  : hv0;
    wire [47:0]  hd       = sel ? hd1  : hd0;
    wire [47:0]  hs       = sel ? hs1  : hs0;
    wire [15:0]  he       = sel ? he1  : he0;
    wire [7:0]   dbg      = sel ? dbg1 : dbg0;

    beat_t exp_q[$];
    hdr_t  hdr_q[$];
    beat_t e;
    hdr_t  h;
    int    n_vec = 0;
    int    n_err = 0;
    int    exp_fc[2];
    int    exp_dc[2];
    bit    saw_flush;

    eth_decap #(.ETYPE_FILTER_EN(1'b0), .ETYPE_MATCH(16'h0800), .CNT_W(16)) dut0 (
        .clk156(clk156), .eth_rst(eth_rst), .debug(dbg0),
        .s_axis_rx0_tvalid(s_tvalid & ~sel), .s_axis_rx0_tready(rdy0),
        .s_axis_rx0_tdata(s_tdata), .s_axis_rx0_tkeep(s_tkeep),
        .s_axis_rx0_tlast(s_tlast), .s_axis_rx0_tuser(s_tuser),
        .m_axis_pl_tvalid(mv0), .m_axis_pl_tready(m_tready),
        .m_axis_pl_tdata(md0), .m_axis_pl_tkeep(mk0),
        .m_axis_pl_tlast(ml0), .m_axis_pl_tuser(mu0),
        .hdr_valid(hv0), .hdr_dst_mac(hd0), .hdr_src_mac(hs0), .hdr_ethertype(he0),
        .frame_cnt(fc0), .drop_cnt(dc0)
    );

    eth_decap #(.ETYPE_FILTER_EN(1'b1), .ETYPE_MATCH(16'h88B5), .CNT_W(16)) dut1 (
        .clk156(clk156), .eth_rst(eth_rst), .debug(dbg1),
        .s_axis_rx0_tvalid(s_tvalid & sel), .s_axis_rx0_tready(rdy1),
        .s_axis_rx0_tdata(s_tdata), .s_axis_rx0_tkeep(s_tkeep),
        .s_axis_rx0_tlast(s_tlast), .s_axis_rx0_tuser(s_tuser),
        .m_axis_pl_tvalid(mv1), .m_axis_pl_tready(m_tready),
        .m_axis_pl_tdata(md1), .m_axis_pl_tkeep(mk1),
        .m_axis_pl_tlast(ml1), .m_axis_pl_tuser(mu1),
        .hdr_valid(hv1), .hdr_dst_mac(hd1), .hdr_src_mac(hs1), .hdr_ethertype(he1),
        .frame_cnt(fc1), .drop_cnt(dc1)
    );

    always #5 clk156 = ~clk156;

    // Output backpressure: always ready, or a coin flip per cycle
    always @(negedge clk156) begin
        m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard: compare every transferred payload beat and header pulse
    always @(negedge clk156) begin
        #2;
        if (mv && m_tready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat got d=%h k=%h l=%b u=%b, expected no beat", md, mk, ml, mu);
            end else begin
                e = exp_q.pop_front();
                if ({md, mk, ml, mu} !== {e.d, e.k, e.l, e.u}) begin
                    n_err++;
                    $display("FAIL payload_beat got d=%h k=%h l=%b u=%b, expected d=%h k=%h l=%b u=%b",
                             md, mk, ml, mu, e.d, e.k, e.l, e.u);
                end
            end
        end
        if (hv) begin
            n_vec++;
            if (hdr_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_hdr got dst=%h src=%h et=%h, expected no header", hd, hs, he);
            end else begin
                h = hdr_q.pop_front();
                if ({hd, hs, he} !== {h.dst, h.src, h.et}) begin
                    n_err++;
                    $display("FAIL header got dst=%h src=%h et=%h, expected dst=%h src=%h et=%h",
                             hd, hs, he, h.dst, h.src, h.et);
                end
            end
        end
        if (dbg[2:0] == 3'd3) begin
            saw_flush = 1'b1;
            n_vec++;
            if (dbg[6] !== 1'b0) begin
                n_err++;
                $display("FAIL flush_tready got %b, expected 0", dbg[6]);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired, got no end of test, expected completion");
        $fatal(1);
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        int   t;
        logic ok;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 500) begin
            #1;
            ok = s_tready;
            @(posedge clk156);
            @(negedge clk156);
            t++;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_accept got no tready after %0d cycles, expected acceptance", t);
        end
    endtask

    // Builds a random frame, pushes the expected result, then drives up to max_beats beats
    task automatic send_frame(input int len, input logic [15:0] et, input int ubeat,
                              input bit idle_after, input int max_beats);
        logic [7:0]  fb[$];
        int          nbeats, plen, pbeats, idx;
        bit          uerr, pass;
        hdr_t        hx;
        beat_t       bx;
        logic [63:0] d;
        logic [7:0]  k;
        for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
        if (len > 12) fb[12] = et[15:8];
        if (len > 13) fb[13] = et[7:0];
        nbeats = (len + 7) / 8;
        uerr   = (ubeat >= 0) && (ubeat < nbeats);
        pass   = (len > 14) && (!sel || et == 16'h88B5);
        if (!pass) begin
            exp_dc[sel]++;
        end else begin
            exp_fc[sel]++;
            hx.dst = 48'd0;
            hx.src = 48'd0;
            for (int i = 0; i < 6; i++) hx.dst = {hx.dst[39:0], fb[i]};
            for (int i = 6; i < 12; i++) hx.src = {hx.src[39:0], fb[i]};
            hx.et = et;
            hdr_q.push_back(hx);
            plen   = len - 14;
            pbeats = (plen + 7) / 8;
            for (int b = 0; b < pbeats; b++) begin
                bx.d = 64'd0;
                bx.k = 8'd0;
                for (int j = 0; j < 8; j++) begin
                    idx = 14 + b * 8 + j;
                    if (idx < len) begin
                        bx.d[j*8 +: 8] = fb[idx];
                        bx.k[j] = 1'b1;
                    end
                end
                bx.l = (b == pbeats - 1);
                bx.u = bx.l && uerr;
                if (b < max_beats - 2) exp_q.push_back(bx);
            end
        end
        for (int b = 0; b < nbeats && b < max_beats; b++) begin
            d = 64'd0;
            k = 8'd0;
            for (int j = 0; j < 8; j++) begin
                if (b * 8 + j < len) begin
                    d[j*8 +: 8] = fb[b * 8 + j];
                    k[j] = 1'b1;
                end
            end
            send_beat(d, k, (b == nbeats - 1), (b == ubeat));
        end
        if (idle_after) begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            s_tuser  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && t < 3000) begin
            @(negedge clk156);
            t++;
        end
        repeat (4) @(negedge clk156);
        n_vec++;
        if (exp_q.size() != 0 || hdr_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d beats and %0d headers pending, expected 0", exp_q.size(), hdr_q.size());
            exp_q.delete();
            hdr_q.delete();
        end
    endtask

    task automatic test_reset();
        eth_rst = 1'b1;
        repeat (3) @(negedge clk156);
        eth_rst = 1'b0;
        #2;
        n_vec++;
        if ({mv0, hv0, fc0, dc0, dbg0} !== {1'b0, 1'b0, 16'd0, 16'd0, 8'h40}) begin
            n_err++;
            $display("FAIL reset_state got mv=%b hv=%b fc=%0d dc=%0d dbg=%h, expected 0 0 0 0 40",
                     mv0, hv0, fc0, dc0, dbg0);
        end
        n_vec++;
        if ({md0, mk0, ml0, mu0, hd0, hs0, he0} !== 186'd0) begin
            n_err++;
            $display("FAIL reset_regs got d=%h k=%h dst=%h src=%h et=%h, expected all 0", md0, mk0, hd0, hs0, he0);
        end
        @(negedge clk156);
    endtask

    task automatic test_basic();
        saw_flush = 1'b0;
        send_frame(64, 16'h0800, -1, 1'b1, 99);
        wait_drain();
        n_vec++;
        if (fc0 !== 16'(exp_fc[0]) || saw_flush !== 1'b1) begin
            n_err++;
            $display("FAIL basic_64 got fc=%0d flush=%b, expected fc=%0d flush=1", fc0, saw_flush, exp_fc[0]);
        end
    endtask

    task automatic test_short();
        saw_flush = 1'b0;
        send_frame(60, 16'h0800, -1, 1'b1, 99);
        wait_drain();
        n_vec++;
        if (fc0 !== 16'(exp_fc[0]) || saw_flush !== 1'b0) begin
            n_err++;
            $display("FAIL short_60 got fc=%0d flush=%b, expected fc=%0d flush=0", fc0, saw_flush, exp_fc[0]);
        end
    endtask

    task automatic test_runt();
        send_frame(14, 16'h0800, -1, 1'b1, 99);
        send_frame(9, 16'h0800, -1, 1'b1, 99);
        wait_drain();
        n_vec++;
        if (dc0 !== 16'd2 || fc0 !== 16'(exp_fc[0])) begin
            n_err++;
            $display("FAIL runt_drop got dc=%0d fc=%0d, expected dc=2 fc=%0d", dc0, fc0, exp_fc[0]);
        end
        send_frame(15, 16'h0800, -1, 1'b1, 99);
        send_frame(8, 16'h0800, -1, 1'b1, 99);
        wait_drain();
        n_vec++;
        if (dc0 !== 16'(exp_dc[0]) || fc0 !== 16'(exp_fc[0])) begin
            n_err++;
            $display("FAIL runt_15 got dc=%0d fc=%0d, expected dc=%0d fc=%0d", dc0, fc0, exp_dc[0], exp_fc[0]);
        end
    endtask

    task automatic test_tuser();
        send_frame(48, 16'h0800, 3, 1'b1, 99);
        send_frame(16, 16'h0800, 1, 1'b1, 99);
        send_frame(40, 16'h0800, -1, 1'b1, 99);
        wait_drain();
        n_vec++;
        if (fc0 !== 16'(exp_fc[0])) begin
            n_err++;
            $display("FAIL tuser_frames got fc=%0d, expected %0d", fc0, exp_fc[0]);
        end
    endtask

    task automatic test_filter();
        sel = 1'b1;
        @(negedge clk156);
        send_frame(40, 16'h0800, -1, 1'b1, 99);
        send_frame(40, 16'h88B5, -1, 1'b1, 99);
        send_frame(31, 16'h0800, -1, 1'b0, 99);
        send_frame(17, 16'h88B5, -1, 1'b1, 99);
        wait_drain();
        n_vec++;
        if (dc1 !== 16'(exp_dc[1]) || fc1 !== 16'(exp_fc[1])) begin
            n_err++;
            $display("FAIL filter_counts got dc=%0d fc=%0d, expected dc=%0d fc=%0d", dc1, fc1, exp_dc[1], exp_fc[1]);
        end
        sel = 1'b0;
        @(negedge clk156);
    endtask

    task automatic test_back_to_back();
        int lens[10] = '{64, 15, 16, 17, 60, 14, 23, 100, 22, 30};
        rnd_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_frame(lens[i], 16'h0800, (i == 7) ? 5 : -1, (i == 9), 99);
        end
        wait_drain();
        rnd_rdy = 1'b0;
        n_vec++;
        if (fc0 !== 16'(exp_fc[0]) || dc0 !== 16'(exp_dc[0])) begin
            n_err++;
            $display("FAIL b2b_counts got fc=%0d dc=%0d, expected fc=%0d dc=%0d", fc0, dc0, exp_fc[0], exp_dc[0]);
        end
    endtask

    task automatic test_reset_mid();
        send_frame(40, 16'h0800, 1, 1'b0, 3);
        s_tvalid = 1'b0;
        eth_rst  = 1'b1;
        @(posedge clk156);
        @(negedge clk156);
        #2;
        n_vec++;
        if ({mv0, fc0, hd0, he0, dbg0[2:0]} !== 84'd0) begin
            n_err++;
            $display("FAIL reset_mid got mv=%b fc=%0d dst=%h et=%h st=%0d, expected all 0",
                     mv0, fc0, hd0, he0, dbg0[2:0]);
        end
        exp_fc[0] = 0;
        exp_dc[0] = 0;
        exp_fc[1] = 0;
        exp_dc[1] = 0;
        eth_rst = 1'b0;
        @(negedge clk156);
        send_frame(37, 16'h0800, -1, 1'b1, 99);
        wait_drain();
        n_vec++;
        if (fc0 !== 16'd1 || dc0 !== 16'd0) begin
            n_err++;
            $display("FAIL reset_recover got fc=%0d dc=%0d, expected fc=1 dc=0", fc0, dc0);
        end
    endtask

    initial begin
        eth_rst  = 1'b1;
        sel      = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 64'd0;
        s_tkeep  = 8'd0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        rnd_rdy  = 1'b0;
        m_tready = 1'b1;
        exp_fc   = '{0, 0};
        exp_dc   = '{0, 0};
        @(negedge clk156);
        test_reset();
        test_basic();
        test_short();
        test_runt();
        test_tuser();
        test_filter();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_decap.md
Name: eth_decap

Overview:
Receive-side counterpart of the transmit encapsulation path on the KC705 10G datapath, in the clk156 domain. Consumes raw Ethernet frames from the MAC RX AXI-Stream (64-bit, byte 0 on tdata[7:0]) and strips the 14-byte L2 header. Presents dst/src MAC and EtherType as registered sideband, and emits the payload realigned to lane 0. Supports optional EtherType filtering, runt dropping, and status counters.

Parameters:
ETYPE_FILTER_EN, 0, 1 drops frames whose EtherType differs from ETYPE_MATCH
ETYPE_MATCH, 16'h0800, accepted EtherType when filtering is enabled
CNT_W, 16, width of frame_cnt and drop_cnt (wrap-around)

Ports:
clk156  in  1  sole clock
eth_rst  in  1  synchronous active-high reset
debug  out  8  {m_axis_pl_tvalid, s_axis_rx0_tready, 3'b0, state[2:0]}
s_axis_rx0_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/64/8/1/1  frame in; tkeep contiguous from lane 0, 8'hFF on non-last beats
m_axis_pl_tvalid/tready/tdata/tkeep/tlast/tuser  out/in/out/out/out/out  1/1/64/8/1/1  payload out
hdr_valid  out  1  one-cycle pulse: header fields updated
hdr_dst_mac  out  48  frame bytes 0..5, byte 0 in [47:40]
hdr_src_mac  out  48  frame bytes 6..11, byte 6 in [47:40]
hdr_ethertype  out  16  {byte12, byte13}
frame_cnt  out  CNT_W  frames whose header was delivered
drop_cnt  out  CNT_W  runt plus filtered frames

Behaviour:
- Reset: state=HDR0; m_axis_pl_tvalid/tdata/tkeep/tlast/tuser=0; hdr_* =0; counters=0; sticky err=0; prev regs=0.
- States: HDR0=0, HDR1=1, BODY=2, FLUSH=3, DROP=4.
- s_axis_rx0_tready: 1 in HDR0/HDR1/DROP; (!m_tvalid || m_tready) in BODY; 0 in FLUSH.
- Output is one register stage. m_tvalid holds until m_tready; data is stable while stalled.
- err: sticky OR of tuser over all accepted beats of the frame; cleared on entry to HDR0.
- HDR0 accept:
  - capture beat as prev.
  - tlast → drop_cnt+1, stay HDR0.
  - else → HDR1.
- HDR1 accept: form header from prev and the current beat; save current beat as prev.
  - Runt: tlast with tkeep[6]=0 (≤14 bytes) → drop_cnt+1, →HDR0, no hdr_valid.
  - Filtered (FILTER_EN and EtherType≠MATCH) → drop_cnt+1, no hdr_valid; tlast ? HDR0 : DROP.
  - Otherwise: hdr_* and hdr_valid=1 registered next cycle, frame_cnt+1; tlast ? FLUSH : BODY.
- BODY accept:
  - output tdata={cur[47:0],prev[63:48]}, tkeep={cur_keep[5:0],prev_keep[7:6]}; prev←cur.
  - If tlast and cur_keep[6]=0: tlast=1, tuser=err|cur_tuser, →HDR0.
  - If tlast and cur_keep[6]=1: tlast=0, →FLUSH.
- FLUSH: when output slot free, emit tdata={48'b0,prev[63:48]}, tkeep={6'b0,prev_keep[7:6]}, tlast=1, tuser=err; →HDR0.
- DROP: discard beats; tlast accepted →HDR0.
- Latency: first payload beat valid 1 cycle after the 3rd input beat is accepted. hdr_valid precedes or coincides with the first payload beat.
- Output tkeep is always contiguous from lane 0. A 1–2 byte payload yields a single FLUSH beat.
- Counters wrap at 2^CNT_W. Header fields hold until the next valid header.
- eth_rst mid-frame: everything returns to reset values next cycle. The in-progress frame is abandoned with no tlast emitted. The next input beat is treated as header byte 0.

Test Plan:
- 64-byte frame, 8 beats of FF, EtherType 0x0800 → hdr_valid once with correct MACs and 16'h0800; 7 payload beats, keep FF×6 then 0x03 via FLUSH; 50 bytes byte-exact; frame_cnt=1.
- 60-byte frame, last in-keep 0x0F → 6 payload beats, last keep 0x3F (46 bytes), no FLUSH state entered.
- 14-byte runt (beat 2 tlast keep 0x3F), then 9-byte runt (beat 2 keep 0x01) → no hdr_valid, no output, drop_cnt=2. A 15-byte frame → one beat, keep 0x01, tlast.
- ETYPE_FILTER_EN=1, MATCH=16'h88B5: 0x0800 frame → dropped, drop_cnt+1, no output; following 0x88B5 frame passes intact.
- m_tready random 50%, back-to-back frames with tvalid constantly high → payload streams byte-exact; s_tready=0 during FLUSH; no beat lost or duplicated.
- tuser=1 on a middle beat → m_tuser=1 only on that frame's last output beat; eth_rst asserted mid-frame → outputs cleared next cycle, next frame decodes correctly.
